// File: rtl/i2c_buf_arbiter.sv
// Grants ifmap buffers to img2col units and routes each unit's write traffic to the buffer it owns.
// Optional macro I2C_ARB_RR_EN: round-robin unit selection instead of fixed lowest-index priority.
module i2c_buf_arbiter #(
  parameter int NUM_UNITS = 2,
  parameter int NUM_BUFS  = 3,
  parameter int SIZE      = 8,
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 1024
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          i2c_go,
  output logic                          i2c_ready,
  output logic                          buf_empty,
  output logic                          tile_continue,
  output logic                          i2c_pulse,
  output logic [NUM_UNITS-1:0]          unit_start,
  output logic [NUM_UNITS-1:0]          unit_busy,
  input  logic [NUM_UNITS-1:0]          i2c_ok,
  input  logic [NUM_UNITS-1:0]          i2c_done,
  input  logic [NUM_UNITS-1:0]          tile_continue_in,
  input  logic [NUM_UNITS*SIZE-1:0]     ifm_wr_enable,
  input  logic [NUM_UNITS*ADDR_W-1:0]   ifm_wr_address,
  input  logic [NUM_UNITS*DATA_W-1:0]   pixels_from_i2c,
  input  logic [NUM_BUFS-1:0]           buf_empty_in,
  output logic [NUM_BUFS*SIZE-1:0]      ifm_wr_en,
  output logic [NUM_BUFS*ADDR_W-1:0]    ifm_wr_addr,
  output logic [NUM_BUFS-1:0]           buf_i2c_ready,
  output logic [NUM_BUFS-1:0]           buf_i2c_finish,
  output logic [NUM_BUFS*DATA_W-1:0]    pixels_to_buffer
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_BUFS-1:0]  own_valid_q, own_valid_d;
  logic [UW-1:0]        own_idx_q [NUM_BUFS];
  logic [UW-1:0]        own_idx_d [NUM_BUFS];
  logic [NUM_UNITS-1:0] busy_q, busy_d;
  logic [NUM_UNITS-1:0] start_q, start_d;
  logic                 guard_q, guard_d;

  logic [NUM_UNITS-1:0] unit_elig;
  logic [NUM_BUFS-1:0]  buf_elig;
  logic                 grant;
  logic [UW-1:0]        sel_unit;
  logic [NUM_BUFS-1:0]  sel_buf_oh;

  assign i2c_ready     = |i2c_ok;
  assign buf_empty     = |buf_empty_in;
  assign tile_continue = |tile_continue_in;
  assign unit_start    = start_q;
  assign i2c_pulse     = |start_q;
  assign unit_busy     = busy_q;

  // Eligibility looks only at registered ownership, so a release is grantable one edge later.
  assign unit_elig = ~busy_q & i2c_ok;
  assign buf_elig  = buf_empty_in & ~own_valid_q;
  assign grant     = i2c_go && (|unit_elig) && (|buf_elig) && !guard_q;

  always_comb begin
    sel_buf_oh = '0;
    for (int j = NUM_BUFS - 1; j >= 0; j--) begin
      if (buf_elig[j]) begin
        sel_buf_oh    = '0;
        sel_buf_oh[j] = 1'b1;
      end
    end
  end

`ifdef I2C_ARB_RR_EN
  logic [UW-1:0] rr_ptr_q, rr_ptr_d;
  logic [UW-1:0] sel_lo, sel_hi;
  logic          hi_found;

  // First eligible unit at or above the pointer wins; otherwise wrap to the lowest eligible one.
  always_comb begin
    sel_lo   = '0;
    sel_hi   = '0;
    hi_found = 1'b0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (unit_elig[k]) begin
        sel_lo = UW'(k);
        if (UW'(k) >= rr_ptr_q) begin
          sel_hi   = UW'(k);
          hi_found = 1'b1;
        end
      end
    end
    sel_unit = hi_found ? sel_hi : sel_lo;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (sel_unit == UW'(NUM_UNITS - 1)) ? '0 : sel_unit + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    sel_unit = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (unit_elig[k]) sel_unit = UW'(k);
    end
  end
`endif

  // Release and grant touch disjoint units/buffers, so both apply on the same edge.
  always_comb begin
    busy_d      = busy_q;
    own_valid_d = own_valid_q;
    own_idx_d   = own_idx_q;
    start_d     = '0;
    guard_d     = grant;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (i2c_done[k] && busy_q[k]) begin
        busy_d[k] = 1'b0;
        for (int j = 0; j < NUM_BUFS; j++) begin
          if (own_valid_q[j] && own_idx_q[j] == UW'(k)) own_valid_d[j] = 1'b0;
        end
      end
    end
    if (grant) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (sel_unit == UW'(k)) begin
          busy_d[k]  = 1'b1;
          start_d[k] = 1'b1;
        end
      end
      for (int j = 0; j < NUM_BUFS; j++) begin
        if (sel_buf_oh[j]) begin
          own_valid_d[j] = 1'b1;
          own_idx_d[j]   = sel_unit;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      own_valid_q <= '0;
      busy_q      <= '0;
      start_q     <= '0;
      guard_q     <= 1'b0;
      for (int j = 0; j < NUM_BUFS; j++) own_idx_q[j] <= '0;
    end else begin
      own_valid_q <= own_valid_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      guard_q     <= guard_d;
      for (int j = 0; j < NUM_BUFS; j++) own_idx_q[j] <= own_idx_d[j];
    end
  end

  for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_route
    logic [SIZE-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pix;
    logic              rdy;
    logic              fin;

    always_comb begin
      we   = '0;
      addr = '0;
      pix  = '0;
      rdy  = 1'b0;
      fin  = 1'b0;
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (own_valid_q[gi] && own_idx_q[gi] == UW'(k)) begin
          we   = ifm_wr_enable[k*SIZE +: SIZE];
          addr = ifm_wr_address[k*ADDR_W +: ADDR_W];
          pix  = pixels_from_i2c[k*DATA_W +: DATA_W];
          rdy  = i2c_ok[k];
          fin  = i2c_done[k];
        end
      end
    end

    assign ifm_wr_en[gi*SIZE +: SIZE]           = we;
    assign ifm_wr_addr[gi*ADDR_W +: ADDR_W]     = addr;
    assign pixels_to_buffer[gi*DATA_W +: DATA_W] = pix;
    assign buf_i2c_ready[gi]                    = rdy;
    assign buf_i2c_finish[gi]                   = fin;
  end

endmodule

// File: tb/tb_i2c_buf_arbiter.sv
// Scoreboard bench for i2c_buf_arbiter: expected grants are queued at stimulus time and
// checked against every start pulse; each scenario task also checks ownership and routing inline.
module tb_i2c_buf_arbiter;

  localparam int NU = 2;
  localparam int NB = 3;
  localparam int SZ = 8;
  localparam int AW = 40;
  localparam int DW = 16;

  logic              clock = 1'b0;
  logic              rst;
  logic              i2c_go;
  logic              i2c_ready, buf_empty, tile_continue, i2c_pulse;
  logic [NU-1:0]     unit_start, unit_busy;
  logic [NU-1:0]     i2c_ok, i2c_done, tile_continue_in;
  logic [NU*SZ-1:0]  ifm_wr_enable;
  logic [NU*AW-1:0]  ifm_wr_address;
  logic [NU*DW-1:0]  pixels_from_i2c;
  logic [NB-1:0]     buf_empty_in;
  logic [NB*SZ-1:0]  ifm_wr_en;
  logic [NB*AW-1:0]  ifm_wr_addr;
  logic [NB-1:0]     buf_i2c_ready, buf_i2c_finish;
  logic [NB*DW-1:0]  pixels_to_buffer;

  typedef struct {
    int u;
    int b;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  i2c_buf_arbiter #(
    .NUM_UNITS(NU), .NUM_BUFS(NB), .SIZE(SZ), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clock(clock), .rst(rst), .i2c_go(i2c_go),
    .i2c_ready(i2c_ready), .buf_empty(buf_empty), .tile_continue(tile_continue),
    .i2c_pulse(i2c_pulse), .unit_start(unit_start), .unit_busy(unit_busy),
    .i2c_ok(i2c_ok), .i2c_done(i2c_done), .tile_continue_in(tile_continue_in),
    .ifm_wr_enable(ifm_wr_enable), .ifm_wr_address(ifm_wr_address),
    .pixels_from_i2c(pixels_from_i2c), .buf_empty_in(buf_empty_in),
    .ifm_wr_en(ifm_wr_en), .ifm_wr_addr(ifm_wr_addr),
    .buf_i2c_ready(buf_i2c_ready), .buf_i2c_finish(buf_i2c_finish),
    .pixels_to_buffer(pixels_to_buffer)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pix_of(int u);
    return DW'(32'hA5A0 + u);
  endfunction

  function automatic logic [AW-1:0] addr_of(int u);
    return AW'(64'h12_3400_0000 + u);
  endfunction

  function automatic logic [SZ-1:0] we_of(int u);
    return SZ'(8'h11 * (u + 1));
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Every start pulse must match the oldest queued grant, with the routed data already in place.
  always @(negedge clock) begin
    exp_t e;
    if (i2c_pulse === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: unit_start=%b required no grant", unit_start);
      end else begin
        e = sb_q.pop_front();
        if (unit_start !== (NU'(1) << e.u) ||
            pixels_to_buffer[e.b*DW +: DW] !== pix_of(e.u) ||
            ifm_wr_addr[e.b*AW +: AW] !== addr_of(e.u) ||
            ifm_wr_en[e.b*SZ +: SZ] !== we_of(e.u)) begin
          errors++;
          $display("FAIL grant_scoreboard: unit_start=%b buf%0d pix=%h addr=%h we=%h required unit %0d (pix=%h addr=%h we=%h)",
                   unit_start, e.b, pixels_to_buffer[e.b*DW +: DW], ifm_wr_addr[e.b*AW +: AW],
                   ifm_wr_en[e.b*SZ +: SZ], e.u, pix_of(e.u), addr_of(e.u), we_of(e.u));
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; i2c_go = 1'b0; i2c_ok = '0; i2c_done = '0; tile_continue_in = '0; buf_empty_in = '0;
    cyc(); cyc();
    @(negedge clock);
    checks++;
    if (unit_start !== '0 || unit_busy !== '0 || i2c_pulse !== 1'b0 || pixels_to_buffer !== '0 ||
        ifm_wr_en !== '0 || ifm_wr_addr !== '0 || buf_i2c_ready !== '0 || buf_i2c_finish !== '0) begin
      errors++;
      $display("FAIL reset_state: start=%b busy=%b pulse=%b pix=%h we=%h required all zero",
               unit_start, unit_busy, i2c_pulse, pixels_to_buffer, ifm_wr_en);
    end
    i2c_ok = 2'b10; buf_empty_in = 3'b100; tile_continue_in = 2'b01; i2c_go = 1'b1;
    #1;
    checks++;
    if ({i2c_ready, buf_empty, tile_continue} !== 3'b111) begin
      errors++;
      $display("FAIL or_in_reset: got %b required 111", {i2c_ready, buf_empty, tile_continue});
    end
    cyc();
    @(negedge clock);
    checks++;
    if (unit_start !== '0 || unit_busy !== '0) begin
      errors++;
      $display("FAIL no_grant_in_reset: start=%b busy=%b required 00 00", unit_start, unit_busy);
    end
    i2c_ok = '0; buf_empty_in = '0; tile_continue_in = '0; i2c_go = 1'b0;
    #1;
    checks++;
    if ({i2c_ready, buf_empty, tile_continue} !== 3'b000) begin
      errors++;
      $display("FAIL or_low: got %b required 000", {i2c_ready, buf_empty, tile_continue});
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_grant_sequence();
    buf_empty_in = 3'b111; i2c_ok = 2'b11; i2c_go = 1'b1;
    sb_q.push_back('{0, 0});
    sb_q.push_back('{1, 1});
    @(negedge clock);
    checks++;
    if (unit_start !== 2'b00) begin
      errors++; $display("FAIL start_before_edge: got %b required 00", unit_start);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (unit_start !== 2'b01 || unit_busy !== 2'b01 || buf_i2c_ready !== 3'b001) begin
      errors++;
      $display("FAIL first_grant: start=%b busy=%b rdy=%b required 01 01 001", unit_start, unit_busy, buf_i2c_ready);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (unit_start !== 2'b00) begin
      errors++; $display("FAIL guard_cycle: got %b required 00", unit_start);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (unit_start !== 2'b10 || unit_busy !== 2'b11 || pixels_to_buffer[1*DW +: DW] !== pix_of(1)) begin
      errors++;
      $display("FAIL second_grant: start=%b busy=%b buf1 pix=%h required 10 11 %h",
               unit_start, unit_busy, pixels_to_buffer[1*DW +: DW], pix_of(1));
    end
    i2c_go = 1'b0;
  endtask

  task automatic test_release();
    cyc();
    i2c_done = 2'b01;
    @(negedge clock);
    checks++;
    if (buf_i2c_finish !== 3'b001 || pixels_to_buffer[0 +: DW] !== pix_of(0)) begin
      errors++;
      $display("FAIL finish_passthrough: fin=%b buf0 pix=%h required 001 %h",
               buf_i2c_finish, pixels_to_buffer[0 +: DW], pix_of(0));
    end
    cyc();
    i2c_done = 2'b00;
    @(negedge clock);
    checks++;
    if (pixels_to_buffer[0 +: DW] !== '0 || ifm_wr_en[0 +: SZ] !== '0 || ifm_wr_addr[0 +: AW] !== '0 ||
        unit_busy !== 2'b10 || buf_i2c_ready !== 3'b010) begin
      errors++;
      $display("FAIL after_release: buf0 pix=%h we=%h busy=%b rdy=%b required 0 0 10 010",
               pixels_to_buffer[0 +: DW], ifm_wr_en[0 +: SZ], unit_busy, buf_i2c_ready);
    end
  endtask

  task automatic test_blocked();
    cyc();
    buf_empty_in = 3'b001; i2c_go = 1'b1;
    sb_q.push_back('{0, 0});
    cyc();
    @(negedge clock);
    checks++;
    if (unit_start !== 2'b01 || unit_busy !== 2'b11) begin
      errors++; $display("FAIL regrant_u0: start=%b busy=%b required 01 11", unit_start, unit_busy);
    end
    buf_empty_in = 3'b100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clock);
      checks++;
      if (unit_start !== 2'b00) begin
        errors++; $display("FAIL blocked_%0d: start=%b required 00", i, unit_start);
      end
    end
    cyc();
    i2c_done = 2'b10;
    sb_q.push_back('{1, 2});
    @(negedge clock);
    checks++;
    if (buf_i2c_finish !== 3'b010) begin
      errors++; $display("FAIL finish_u1: fin=%b required 010", buf_i2c_finish);
    end
    cyc();
    i2c_done = 2'b00;
    @(negedge clock);
    checks++;
    if (unit_start !== 2'b00 || unit_busy !== 2'b01) begin
      errors++;
      $display("FAIL release_edge_no_grant: start=%b busy=%b required 00 01", unit_start, unit_busy);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (unit_start !== 2'b10 || unit_busy !== 2'b11 || buf_i2c_ready !== 3'b101) begin
      errors++;
      $display("FAIL grant_after_release: start=%b busy=%b rdy=%b required 10 11 101",
               unit_start, unit_busy, buf_i2c_ready);
    end
    i2c_go = 1'b0;
  endtask

  task automatic test_unit_select();
    int nxt;
    int other;
`ifdef I2C_ARB_RR_EN
    nxt = 1;
`else
    nxt = 0;
`endif
    other = 1 - nxt;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    buf_empty_in = 3'b111; i2c_ok = 2'b11; i2c_go = 1'b1;
    sb_q.push_back('{0, 0});
    cyc();
    i2c_go = 1'b0;
    @(negedge clock);
    checks++;
    if (unit_start !== 2'b01) begin
      errors++; $display("FAIL sel_first: start=%b required 01", unit_start);
    end
    cyc();
    i2c_done = 2'b01;
    cyc();
    i2c_done = 2'b00; i2c_go = 1'b1;
    sb_q.push_back('{nxt, 0});
    @(negedge clock);
    checks++;
    if (unit_busy !== 2'b00) begin
      errors++; $display("FAIL sel_released: busy=%b required 00", unit_busy);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (unit_start !== (NU'(1) << nxt)) begin
      errors++; $display("FAIL sel_next_unit: start=%b required unit %0d", unit_start, nxt);
    end
    sb_q.push_back('{other, 1});
    cyc();
    cyc();
    i2c_go = 1'b0;
    @(negedge clock);
    checks++;
    if (unit_start !== (NU'(1) << other) || unit_busy !== 2'b11) begin
      errors++;
      $display("FAIL sel_other_unit: start=%b busy=%b required unit %0d busy 11", unit_start, unit_busy, other);
    end
  endtask

  task automatic test_reset_midjob();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clock);
    checks++;
    if (unit_busy !== '0 || unit_start !== '0 || pixels_to_buffer !== '0 || ifm_wr_addr !== '0 ||
        buf_i2c_ready !== '0) begin
      errors++;
      $display("FAIL midjob_reset: busy=%b start=%b rdy=%b pix=%h required all zero",
               unit_busy, unit_start, buf_i2c_ready, pixels_to_buffer);
    end
    i2c_done = 2'b11;
    #1;
    checks++;
    if (buf_i2c_finish !== '0) begin
      errors++; $display("FAIL stray_done_finish: fin=%b required 000", buf_i2c_finish);
    end
    cyc();
    i2c_done = 2'b00;
    @(negedge clock);
    checks++;
    if (unit_busy !== '0 || unit_start !== '0 || pixels_to_buffer !== '0 || ifm_wr_en !== '0) begin
      errors++;
      $display("FAIL stray_done_effect: busy=%b start=%b we=%h required all zero", unit_busy, unit_start, ifm_wr_en);
    end
  endtask

  task automatic drain_scoreboard();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) cyc();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL missing_grants: %0d outstanding required 0", sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; i2c_go = 1'b0; i2c_ok = '0; i2c_done = '0; tile_continue_in = '0; buf_empty_in = '0;
    for (int k = 0; k < NU; k++) begin
      pixels_from_i2c[k*DW +: DW] = pix_of(k);
      ifm_wr_address[k*AW +: AW]  = addr_of(k);
      ifm_wr_enable[k*SZ +: SZ]   = we_of(k);
    end
    test_reset();
    test_grant_sequence();
    test_release();
    test_blocked();
    test_unit_select();
    test_reset_midjob();
    drain_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_buf_arbiter.md
I2C_BUF_ARBITER -- requirements
Module: i2c_buf_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 2: number of img2col units, legal 1..4.
REQ-002 SHALL have parameter NUM_BUFS, default 3: number of ifmap buffers, legal 1..8.
REQ-003 SHALL have parameter SIZE, default 8: write-enable width per buffer.
REQ-004 SHALL have parameter ADDR_W, default 40: write-address width.
REQ-005 SHALL have parameter DATA_W, default 1024: pixel bus width.
REQ-006 SHALL have one clock and a synchronous, active-high reset:
- clock  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have these ports; all vectors are flattened, and slice k belongs to unit k or buffer k:
- i2c_go  in  1  controller permits a new img2col job.
- i2c_ready  out  1  OR of all i2c_ok.
- buf_empty  out  1  OR of all buf_empty_in.
- tile_continue  out  1  OR of all tile_continue_in.
- i2c_pulse  out  1  high for the cycle in which any unit_start is high.
- unit_start  out  NUM_UNITS  one-cycle start pulse per unit.
- unit_busy  out  NUM_UNITS  unit currently owns a buffer.
- i2c_ok, i2c_done, tile_continue_in  in  NUM_UNITS  per-unit status.
- ifm_wr_enable  in  NUM_UNITS*SIZE  per-unit write enables.
- ifm_wr_address  in  NUM_UNITS*ADDR_W  per-unit write addresses.
- pixels_from_i2c  in  NUM_UNITS*DATA_W  per-unit pixel data.
- buf_empty_in  in  NUM_BUFS  per-buffer empty flags.
- ifm_wr_en  out  NUM_BUFS*SIZE  routed write enables.
- ifm_wr_addr  out  NUM_BUFS*ADDR_W  routed write addresses.
- buf_i2c_ready, buf_i2c_finish  out  NUM_BUFS  routed i2c_ok / i2c_done.
- pixels_to_buffer  out  NUM_BUFS*DATA_W  routed pixel data.

Function
REQ-008 SHALL keep, per buffer j, a registered owner valid bit and an owner unit index; per unit k, a registered busy bit.
REQ-009 SHALL route all data outputs of buffer j combinationally from its owner unit while the owner is valid, and drive them to 0 otherwise.
REQ-010 SHALL treat unit k as eligible when busy[k]=0 and i2c_ok[k]=1, and buffer j as eligible when buf_empty_in[j]=1 and its owner is not valid.
REQ-011 SHALL form the grant condition as i2c_go AND at least one eligible unit AND at least one eligible buffer AND guard=0.
REQ-012 SHALL, on a grant at edge t:
- select the lowest-index eligible buffer;
- set that buffer's owner to the selected unit and set the unit's busy bit;
- pulse unit_start[unit] and i2c_pulse high for exactly the cycle following edge t;
- route data to the buffer from that cycle on.
REQ-013 SHALL make at most one grant per edge, and SHALL set guard=1 for the single cycle after each grant; no grant is made while guard=1.
REQ-014 SHALL, on an edge where i2c_done[k]=1 and busy[k]=1, clear busy[k] and invalidate the owner of every buffer owned by k; buf_i2c_finish still passes done through during that cycle.
REQ-015 SHALL ignore i2c_done[k] when busy[k]=0.
REQ-016 SHALL evaluate eligibility from registered state only: a unit or buffer released at edge t is grantable no earlier than edge t+1.
REQ-017 SHALL, when a grant and a release occur on the same edge, perform both independently.
REQ-018 SHALL ensure no buffer ever has two owners and no unit owns two buffers.

Reset
REQ-019 SHALL, on any edge with rst=1 (including mid-job), clear all owner valid bits, busy bits, guard and the round-robin pointer to 0, so that unit_start, i2c_pulse and all routed outputs are 0 from the following cycle.
REQ-020 SHALL keep the combinational OR outputs (i2c_ready, buf_empty, tile_continue) tracking their inputs during reset.

Configuration
REQ-021 SHALL, with macro I2C_ARB_RR_EN defined, select units round-robin, starting from the index after the last granted unit (pointer 0 after reset).
REQ-022 SHALL, with I2C_ARB_RR_EN undefined, select the lowest-index eligible unit and omit the pointer register.

Verification (NUM_UNITS=2, NUM_BUFS=3)
REQ-023 SHALL cover: reset, then buf_empty_in=3'b111, i2c_ok=2'b11, i2c_go=1 -> unit_start=2'b01 one cycle later, buf0 owned by u0, no grant the next cycle, then unit_start=2'b10 with buf1 owned by u1.
REQ-024 SHALL cover: u0 owns buf0 and i2c_done[0]=1 for one cycle -> buf_i2c_finish[0]=1 that cycle, then buf0 outputs=0 and unit_busy[0]=0 the next cycle.
REQ-025 SHALL cover: both units busy, buf2 empty, i2c_go=1 -> no unit_start until a done, then a grant on the edge after the release.
REQ-026 SHALL cover: with I2C_ARB_RR_EN, u0 done after the first grant and both units eligible -> next grant goes to u1; without the macro -> to u0.
REQ-027 SHALL cover: rst=1 while both units are busy -> all owners clear, and a stray i2c_done=2'b11 afterwards produces no change.
